adder_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational 5-bit adder among up to four requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives the shared adder's operand inputs. It captures the sum plus a derived carry flag and returns the result, tagged with the requester ID, over a single valid/ready response channel. It sits between requesting units and the single adder instance in the datapath.

---
 rtl/adder_share_arbiter_if.sv | 29 ++
 rtl/adder_share_arbiter.sv | 115 +++++++++++
 tb/tb_adder_share_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_share_arbiter_if.sv
// Handshake and adder bus between up to four requesters, the shared adder,
// the result consumer and adder_share_arbiter.
interface adder_share_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 5
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]       add_a;
  logic [WIDTH-1:0]       add_b;
  logic [WIDTH-1:0]       add_sum;
  logic                   rsp_valid;
  logic [1:0]             rsp_id;
  logic [WIDTH-1:0]       rsp_sum;
  logic                   rsp_carry;
  logic                   rsp_ready;

  modport slave (
    input  req_valid, req_a, req_b, add_sum, rsp_ready,
    output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );

  modport master (
    output req_valid, req_a, req_b, add_sum, rsp_ready,
    input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin sequencer sharing one combinational adder among N_REQ requesters;
// one transaction in flight at a time, result returned with requester tag and carry.
module adder_share_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adder_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [1:0]       latchedId;
  logic             rspValid;
  logic [1:0]       rspId;
  logic [WIDTH-1:0] rspSum;
  logic             rspCarry;

  logic             grantValid;
  logic [1:0]       grantIdx;
  logic [2:0]       cand;
  logic [1:0]       nextPtr;
  logic [N_REQ-1:0] reqReady;

  // Search ptr, ptr+1, ... with wrap; the first valid requester wins.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + 3'(k);
      if (cand >= 3'(N_REQ)) begin
        cand = cand - 3'(N_REQ);
      end
      if (!grantValid && bus.req_valid[cand[1:0]]) begin
        grantValid = 1'b1;
        grantIdx   = cand[1:0];
      end
    end
  end

  always_comb begin
    nextPtr = (grantIdx == 2'(N_REQ - 1)) ? '0 : grantIdx + 2'd1;
  end

  // Accept pulse is combinational; gated by rst_n so outputs read 0 during reset.
  always_comb begin
    reqReady = '0;
    if (rst_n && (state == IDLE) && grantValid) begin
      reqReady[grantIdx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      opA       <= '0;
      opB       <= '0;
      latchedId <= '0;
      rspValid  <= 1'b0;
      rspId     <= '0;
      rspSum    <= '0;
      rspCarry  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grantValid) begin
            opA       <= bus.req_a[grantIdx*WIDTH +: WIDTH];
            opB       <= bus.req_b[grantIdx*WIDTH +: WIDTH];
            latchedId <= grantIdx;
            ptr       <= nextPtr;
            state     <= EXEC;
          end
        end
        EXEC: begin
          // Adder has no carry port: a wrapped sum is smaller than either operand.
          rspSum   <= bus.add_sum;
          rspCarry <= (bus.add_sum < opA);
          rspId    <= latchedId;
          rspValid <= 1'b1;
          state    <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rspValid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          rspValid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = reqReady;
  assign bus.add_a     = opA;
  assign bus.add_b     = opB;
  assign bus.rsp_valid = rspValid;
  assign bus.rsp_id    = rspId;
  assign bus.rsp_sum   = rspSum;
  assign bus.rsp_carry = rspCarry;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: directed operand vectors with
// hand-computed sums, expected grants and responses checked by separate monitors.
module tb_adder_share_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned W  = 5;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         carry;
  } op_t;

  typedef struct {
    int           id;
    logic [W-1:0] sum;
    logic         carry;
    int           acceptCycle;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_share_arbiter_if #(.N_REQ(NR), .WIDTH(W)) bus();

  adder_share_arbiter #(.N_REQ(NR), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  op_t  opQ[NR][$];
  rsp_t expQ[$];
  int   expGrantQ[$];

  logic [NR-1:0]   modelValid  = '0;
  logic [NR-1:0]   glitch      = '0;
  logic [NR-1:0]   acceptedVec = '0;
  logic [NR*W-1:0] reqA = '0;
  logic [NR*W-1:0] reqB = '0;
  logic            rspReady = 1'b1;

  int   cycle = 0;
  int   checks = 0;
  int   failures = 0;
  int   acceptCycle[NR];
  int   hsCycle[NR];
  logic prevValid = 1'b0;

  assign bus.req_valid = modelValid | glitch;
  assign bus.req_a     = reqA;
  assign bus.req_b     = reqB;
  assign bus.rsp_ready = rspReady;
  assign bus.add_sum   = bus.add_a + bus.add_b;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  always @(posedge clk) cycle++;

  // Requesters: hold valid/operands until accepted, then present the next queued op.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acceptedVec[i] && opQ[i].size() > 0) void'(opQ[i].pop_front());
      if (opQ[i].size() > 0) begin
        modelValid[i]   = 1'b1;
        reqA[i*W +: W]  = opQ[i][0].a;
        reqB[i*W +: W]  = opQ[i][0].b;
      end else begin
        modelValid[i] = 1'b0;
      end
    end
    acceptedVec = '0;
  end

  // Grant monitor: checks the one-hot accept against the expected grant order.
  always @(negedge clk) begin : grantMon
    int g;
    rsp_t e;
    if (rst_n && bus.req_ready != '0) begin
      g = 0;
      for (int i = NR - 1; i >= 0; i--) if (bus.req_ready[i]) g = i;
      if (expGrantQ.size() == 0) begin
        check("unexpected_grant", int'(bus.req_ready), 0);
      end else begin
        check("grant_onehot", int'(bus.req_ready), 1 << expGrantQ.pop_front());
      end
      acceptedVec    = bus.req_ready;
      acceptCycle[g] = cycle;
      if (opQ[g].size() > 0) begin
        e.id          = g;
        e.sum         = opQ[g][0].sum;
        e.carry       = opQ[g][0].carry;
        e.acceptCycle = cycle;
        expQ.push_back(e);
      end
    end
  end

  // Response monitor: compares every presented response cycle against the scoreboard head.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevValid = 1'b0;
    end else begin
      if (bus.rsp_valid) begin
        check("req_ready_in_resp", int'(bus.req_ready), 0);
        if (expQ.size() == 0) begin
          check("unexpected_rsp", int'(bus.rsp_valid), 0);
        end else begin
          if (!prevValid) check("latency", cycle, expQ[0].acceptCycle + 2);
          check("rsp_id", int'(bus.rsp_id), expQ[0].id);
          check("rsp_sum", int'(bus.rsp_sum), int'(expQ[0].sum));
          check("rsp_carry", int'(bus.rsp_carry), int'(expQ[0].carry));
          if (bus.rsp_ready) begin
            hsCycle[expQ[0].id] = cycle;
            void'(expQ.pop_front());
          end
        end
      end
      prevValid = bus.rsp_valid;
    end
  end

  task automatic pushOp(input int id, input int a, input int b, input int sum, input int carry);
    op_t o;
    o.a     = W'(a);
    o.b     = W'(b);
    o.sum   = W'(sum);
    o.carry = 1'(carry);
    opQ[id].push_back(o);
  endtask

  function automatic bit busy();
    bit any = 0;
    for (int i = 0; i < NR; i++) if (opQ[i].size() > 0) any = 1;
    return any || (modelValid != '0) || (expQ.size() > 0) || (bus.rsp_valid === 1'b1);
  endfunction

  task automatic waitDrain(input string tag, input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: still busy after %0d cycles, expected drained", tag, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic waitRsp(input string tag, input int budget);
    int n = 0;
    while (bus.rsp_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: rsp_valid=0 after %0d cycles, expected 1", tag, budget);
    end
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_req_ready"}, int'(bus.req_ready), 0);
    check({tag, "_add_a"},     int'(bus.add_a), 0);
    check({tag, "_add_b"},     int'(bus.add_b), 0);
    check({tag, "_rsp_valid"}, int'(bus.rsp_valid), 0);
    check({tag, "_rsp_id"},    int'(bus.rsp_id), 0);
    check({tag, "_rsp_sum"},   int'(bus.rsp_sum), 0);
    check({tag, "_rsp_carry"}, int'(bus.rsp_carry), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single request: 3 + 4 = 7 from requester 2.
    pushOp(2, 3, 4, 7, 0);
    expGrantQ.push_back(2);
    waitDrain("single", 20);

    // Carry and wrap on requester 0.
    pushOp(0, 20, 15, 3, 1);
    pushOp(0, 31, 1, 0, 1);
    pushOp(0, 31, 0, 31, 0);
    expGrantQ.push_back(0);
    expGrantQ.push_back(0);
    expGrantQ.push_back(0);
    waitDrain("carry", 40);

    // Move the pointer to 0, then all four valid together.
    pushOp(3, 1, 1, 2, 0);
    expGrantQ.push_back(3);
    waitDrain("align", 20);
    pushOp(0, 1, 2, 3, 0);
    pushOp(0, 30, 5, 3, 1);
    pushOp(1, 4, 4, 8, 0);
    pushOp(2, 10, 11, 21, 0);
    pushOp(3, 16, 16, 0, 1);
    foreach (expGrantQ[i]) ;
    expGrantQ.push_back(0);
    expGrantQ.push_back(1);
    expGrantQ.push_back(2);
    expGrantQ.push_back(3);
    expGrantQ.push_back(0);
    waitDrain("round_robin", 60);

    // Backpressure with requesters 1 and 3 waiting (pointer now at 1).
    @(posedge clk); #1;
    rspReady = 1'b0;
    pushOp(1, 7, 8, 15, 0);
    pushOp(3, 25, 9, 2, 1);
    expGrantQ.push_back(1);
    expGrantQ.push_back(3);
    waitRsp("bp", 20);
    repeat (5) @(posedge clk);
    #1 rspReady = 1'b1;
    waitDrain("bp", 30);
    check("bp_next_grant_cycle", acceptCycle[3], hsCycle[1] + 1);

    // Reset during EXEC abandons the request and restores pointer 0.
    pushOp(0, 5, 5, 10, 0);
    expGrantQ.push_back(0);
    n = 0;
    while (expQ.size() == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL rst_accept_timeout: no accept after %0d cycles, expected one", n);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    expQ.delete();
    #1 checkAllZero("rst_async");
    pushOp(1, 2, 3, 5, 0);
    pushOp(0, 6, 7, 13, 0);
    expGrantQ.push_back(0);
    expGrantQ.push_back(1);
    repeat (2) @(negedge clk);
    checkAllZero("rst_hold");
    rst_n = 1'b1;
    waitDrain("post_reset", 30);

    // Requester 1 pulses valid only while the block is in RESP.
    @(posedge clk); #1;
    rspReady = 1'b0;
    pushOp(3, 17, 14, 31, 0);
    expGrantQ.push_back(3);
    waitRsp("withdraw", 20);
    @(posedge clk); #1;
    reqA[1*W +: W] = 5'd9;
    reqB[1*W +: W] = 5'd9;
    glitch[1] = 1'b1;
    @(posedge clk); #1;
    glitch[1] = 1'b0;
    rspReady  = 1'b1;
    waitDrain("withdraw", 20);
    repeat (6) @(negedge clk);

    check("grants_all_seen", expGrantQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
